// File: rtl/digidoggs_pkg.sv
// Shared constants and types for the SPI configuration receiver.
// Frame length depends on SPI_PARITY_EN (adds a trailing even-parity bit).
package digidoggs_pkg;

  localparam logic [7:0] ADDR_CENTER_X = 8'h00;
  localparam logic [7:0] ADDR_CENTER_Y = 8'h01;
  localparam logic [7:0] ADDR_SCALE    = 8'h02;
  localparam logic [7:0] ADDR_MAX_ITER = 8'h03;
  localparam logic [7:0] ADDR_CTRL     = 8'h04;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_CLR_ERR = 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_EN} state_t;

  function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef SPI_PARITY_EN
    return data_w + 9;
`else
    return data_w + 8;
`endif
  endfunction

endpackage

// File: rtl/spi_config_rx_if.sv
// Active render configuration plus start valid/ready handshake toward the engine.
interface spi_config_rx_if #(parameter int unsigned DATA_W = 32);

  logic [DATA_W-1:0] cfg_center_x;
  logic [DATA_W-1:0] cfg_center_y;
  logic [DATA_W-1:0] cfg_scale;
  logic [15:0]       cfg_max_iter;
  logic              start_valid;
  logic              start_ready;

  modport master (
    output cfg_center_x, cfg_center_y, cfg_scale, cfg_max_iter, start_valid,
    input  start_ready
  );

  modport slave (
    input  cfg_center_x, cfg_center_y, cfg_scale, cfg_max_iter, start_valid,
    output start_ready
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronises the asynchronous SPI inputs and flags spi_clk rising edges.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_en,
  input  logic spi_data,
  output logic spi_rise_c,
  output logic spi_en_s,
  output logic spi_data_s
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] en_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q    <= '0;
      en_q     <= '0;
      data_q   <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_q    <= {clk_q[SYNC_STAGES-2:0], spi_clk};
      en_q     <= {en_q[SYNC_STAGES-2:0], spi_en};
      data_q   <= {data_q[SYNC_STAGES-2:0], spi_data};
      clk_prev <= clk_q[SYNC_STAGES-1];
    end
  end

  // Data shares the clock's sync depth, so it is sampled in the edge cycle.
  assign spi_rise_c = clk_q[SYNC_STAGES-1] & ~clk_prev;
  assign spi_en_s   = en_q[SYNC_STAGES-1];
  assign spi_data_s = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_config_rx.sv
// SPI frame receiver with staging/active render config and start handshake.
// Define SPI_PARITY_EN to append and check an even-parity bit per frame.
module spi_config_rx
  import digidoggs_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [15:0] MAX_ITER_RST = 16'd255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ncs,
  input  logic               spi_clk,
  input  logic               spi_en,
  input  logic               spi_data,
  spi_config_rx_if.master    cfg_if,
  output logic               busy,
  output logic               frame_err
);

  localparam int unsigned FRAME_BITS = frame_bits(DATA_W);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  logic                  spi_rise_c;
  logic                  spi_en_s;
  logic                  spi_data_s;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     stg_cx, stg_cy, stg_sc;
  logic [15:0]           stg_mi;
  logic [DATA_W-1:0]     act_cx, act_cy, act_sc;
  logic [15:0]           act_mi;
  logic                  start_valid;

  logic [7:0]            addr_c;
  logic [DATA_W-1:0]     data_c;
  logic                  parity_ok_c;
  logic                  hs_c;
  logic [FRAME_BITS-1:0] shift_c;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_en     (spi_en),
    .spi_data   (spi_data),
    .spi_rise_c (spi_rise_c),
    .spi_en_s   (spi_en_s),
    .spi_data_s (spi_data_s)
  );

  assign addr_c = shreg[FRAME_BITS-1 -: 8];
`ifdef SPI_PARITY_EN
  assign data_c      = shreg[DATA_W:1];
  assign parity_ok_c = ~^shreg;
`else
  assign data_c      = shreg[DATA_W-1:0];
  assign parity_ok_c = 1'b1;
`endif
  assign shift_c = {shreg[FRAME_BITS-2:0], spi_data_s};
  assign hs_c    = start_valid & cfg_if.start_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      stg_cx      <= '0;
      stg_cy      <= '0;
      stg_sc      <= '0;
      stg_mi      <= MAX_ITER_RST;
      act_cx      <= '0;
      act_cy      <= '0;
      act_sc      <= '0;
      act_mi      <= MAX_ITER_RST;
      start_valid <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // Handshake snapshots staging as it stood before any same-cycle write.
      if (hs_c) begin
        act_cx      <= stg_cx;
        act_cy      <= stg_cy;
        act_sc      <= stg_sc;
        act_mi      <= stg_mi;
        start_valid <= 1'b0;
      end

      if (ncs) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (spi_en_s && spi_rise_c) begin
              shreg <= shift_c;
              cnt   <= CNT_W'(1);
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
          SHIFT: begin
            if (!spi_en_s) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else if (spi_rise_c) begin
              shreg <= shift_c;
              cnt   <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(FRAME_BITS - 1)) state <= COMMIT;
            end
          end
          COMMIT: begin
            if (!parity_ok_c) begin
              frame_err <= 1'b1;
            end else begin
              case (addr_c)
                ADDR_CENTER_X: stg_cx <= data_c;
                ADDR_CENTER_Y: stg_cy <= data_c;
                ADDR_SCALE:    stg_sc <= data_c;
                ADDR_MAX_ITER: stg_mi <= data_c[15:0];
                ADDR_CTRL: begin
                  if (data_c[CTRL_CLR_ERR]) frame_err <= 1'b0;
                  if (data_c[CTRL_START] && !start_valid) start_valid <= 1'b1;
                end
                default: ;
              endcase
            end
            state <= spi_en_s ? WAIT_EN : IDLE;
            busy  <= spi_en_s;
          end
          WAIT_EN: begin
            if (!spi_en_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_if.cfg_center_x = act_cx;
  assign cfg_if.cfg_center_y = act_cy;
  assign cfg_if.cfg_scale    = act_sc;
  assign cfg_if.cfg_max_iter = act_mi;
  assign cfg_if.start_valid  = start_valid;

endmodule

// File: tb/tb_spi_config_rx.sv
// Scoreboard bench: bit-banged SPI frames vs. a register-map model; a monitor
// checks the active config after every start handshake.
module tb_spi_config_rx;

`ifdef SPI_PARITY_EN
  localparam int FB = 41;
`else
  localparam int FB = 40;
`endif
  localparam int SYNC = 2;

  logic clk, rst, ncs, spi_clk, spi_en, spi_data, busy, frame_err;

  spi_config_rx_if #(.DATA_W(32)) cfg_if ();

  spi_config_rx #(.DATA_W(32), .SYNC_STAGES(SYNC), .MAX_ITER_RST(16'd255)) dut (
    .clk      (clk),
    .rst      (rst),
    .ncs      (ncs),
    .spi_clk  (spi_clk),
    .spi_en   (spi_en),
    .spi_data (spi_data),
    .cfg_if   (cfg_if),
    .busy     (busy),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [31:0] cx, cy, sc;
    logic [15:0] mi;
    int          hold;
    bit          exact;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] m_st[4];
  logic [31:0] m_act[4];
  bit          m_err, m_pending;
  int          checks, errors, hs_cnt, vcyc, vcyc_hs;
  bit          seen_hs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [7:0] a, input logic [31:0] d);
    logic [63:0] r;
    r = '0;
`ifdef SPI_PARITY_EN
    r[40:0] = {a, d, ^{a, d}};
`else
    r[39:0] = {a, d};
`endif
    return r;
  endfunction

  task automatic shift_bits(input logic [63:0] bits, input int n);
    int h;
    h = $urandom_range(2, 4);
    for (int i = n - 1; i >= 0; i--) begin
      spi_data = bits[i];
      tick(h);
      spi_clk = 1'b1;
      tick(h);
      spi_clk = 1'b0;
    end
  endtask

  task automatic begin_frame();
    ncs = 1'b0;
    spi_en = 1'b1;
    tick(3);
  endtask

  task automatic end_frame();
    tick(2);
    spi_en = 1'b0;
    tick(SYNC + 4);
  endtask

  function automatic exp_t snap(input int hold, input bit exact);
    exp_t x;
    x.cx = m_st[0]; x.cy = m_st[1]; x.sc = m_st[2]; x.mi = m_st[3][15:0];
    x.hold = hold; x.exact = exact;
    return x;
  endfunction

  // Full frame plus reference-model update of the register map.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    if (a == 8'h04 && d[0] && !m_pending) begin
      if (cfg_if.start_ready) q.push_back(snap(1, 1'b1));
      else m_pending = 1'b1;
    end
    begin_frame();
    shift_bits(mk(a, d), FB);
    end_frame();
    case (a)
      8'h00: m_st[0] = d;
      8'h01: m_st[1] = d;
      8'h02: m_st[2] = d;
      8'h03: m_st[3] = {16'h0, d[15:0]};
      8'h04: if (d[1]) m_err = 1'b0;
      default: ;
    endcase
    chk("frame_err_after_wr", frame_err, m_err);
  endtask

  task automatic release_ready(input int min_hold);
    int start_cnt;
    bit done;
    q.push_back(snap(min_hold, 1'b0));
    start_cnt = hs_cnt;
    done = 1'b0;
    cfg_if.start_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(1);
      if (hs_cnt != start_cnt) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=none required=handshake");
    end
    cfg_if.start_ready = 1'b0;
    m_pending = 1'b0;
    tick(1);
  endtask

  task automatic short_frame(input logic [7:0] a, input logic [31:0] d, input int len);
    begin_frame();
    shift_bits(mk(a, d) >> (FB - len), len);
    end_frame();
    m_err = 1'b1;
    chk("frame_err_short", frame_err, 1'b1);
  endtask

  // Monitor: compare active config one cycle after each handshake.
  always @(negedge clk) begin
    if (seen_hs) begin
      seen_hs = 1'b0;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake actual=handshake required=none");
      end else begin
        e = q.pop_front();
        chk("cfg_center_x", cfg_if.cfg_center_x, e.cx);
        chk("cfg_center_y", cfg_if.cfg_center_y, e.cy);
        chk("cfg_scale", cfg_if.cfg_scale, e.sc);
        chk("cfg_max_iter", cfg_if.cfg_max_iter, e.mi);
        chk("start_valid_after_hs", cfg_if.start_valid, 1'b0);
        chk("valid_hold", e.exact ? vcyc_hs : (vcyc_hs >= e.hold ? e.hold : vcyc_hs), e.hold);
        m_act[0] = e.cx; m_act[1] = e.cy; m_act[2] = e.sc; m_act[3] = {16'h0, e.mi};
      end
      hs_cnt++;
    end
    if (!rst && cfg_if.start_valid) vcyc++;
    if (!rst && cfg_if.start_valid && cfg_if.start_ready) begin
      vcyc_hs = vcyc;
      vcyc = 0;
      seen_hs = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    int          r;
    checks = 0; errors = 0; hs_cnt = 0; vcyc = 0; vcyc_hs = 0; seen_hs = 1'b0;
    m_err = 1'b0; m_pending = 1'b0;
    m_st[0] = 0; m_st[1] = 0; m_st[2] = 0; m_st[3] = 32'd255;
    m_act[0] = 0; m_act[1] = 0; m_act[2] = 0; m_act[3] = 32'd255;
    rst = 1'b1; ncs = 1'b1; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0;
    cfg_if.start_ready = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);

    chk("rst_center_x", cfg_if.cfg_center_x, 0);
    chk("rst_center_y", cfg_if.cfg_center_y, 0);
    chk("rst_scale", cfg_if.cfg_scale, 0);
    chk("rst_max_iter", cfg_if.cfg_max_iter, 255);
    chk("rst_start_valid", cfg_if.start_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    ncs = 1'b0;
    tick(2);

    // Write centre X then start with ready already high.
    cfg_if.start_ready = 1'b1;
    wr(8'h00, 32'h1234_5678);
    wr(8'h04, 32'h1);
    cfg_if.start_ready = 1'b0;
    chk("cx_after_start", cfg_if.cfg_center_x, 32'h1234_5678);

    // Start held pending; staging write during the wait is included.
    wr(8'h03, 32'h0000_03E8);
    wr(8'h04, 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("pending_valid", cfg_if.start_valid, 1'b1);
    end
    chk("pending_max_iter", cfg_if.cfg_max_iter, m_act[3][15:0]);
    wr(8'h02, 32'h0000_0100);
    chk("pending_scale", cfg_if.cfg_scale, m_act[2]);
    release_ready(20);
    chk("max_iter_1000", cfg_if.cfg_max_iter, 16'd1000);
    chk("scale_100", cfg_if.cfg_scale, 32'h100);

    // Short frame then clear.
    short_frame(8'h01, $urandom, 20);
    wr(8'h04, 32'h2);
    chk("err_cleared", frame_err, 1'b0);

    // ncs abort mid-frame.
    begin_frame();
    shift_bits(mk(8'h01, 32'hDEAD_BEEF) >> (FB - 10), 10);
    tick(2);
    chk("busy_mid_frame", busy, 1'b1);
    ncs = 1'b1;
    tick(3);
    chk("busy_after_ncs", busy, 1'b0);
    chk("err_after_ncs", frame_err, 1'b0);
    spi_en = 1'b0;
    tick(6);
    ncs = 1'b0;
    tick(2);
    d = $urandom;
    wr(8'h01, d);
    cfg_if.start_ready = 1'b1;
    wr(8'h04, 32'h1);
    cfg_if.start_ready = 1'b0;

    // Over-length frame: trailing bits ignored.
    d = $urandom;
    begin_frame();
    shift_bits(mk(8'h02, d), FB);
    shift_bits(64'($urandom), 5);
    end_frame();
    m_st[2] = d;
    chk("err_over_length", frame_err, m_err);
    cfg_if.start_ready = 1'b1;
    wr(8'h04, 32'h1);
    cfg_if.start_ready = 1'b0;

`ifdef SPI_PARITY_EN
    begin_frame();
    shift_bits(mk(8'h00, $urandom) ^ 64'h1, FB);
    end_frame();
    m_err = 1'b1;
    chk("err_bad_parity", frame_err, 1'b1);
    wr(8'h04, 32'h2);
    cfg_if.start_ready = 1'b1;
    wr(8'h04, 32'h1);
    cfg_if.start_ready = 1'b0;
`endif

    // Randomised traffic.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        a = 8'($urandom_range(0, 6));
        d = $urandom;
        wr(a, d);
      end else if (r == 6) begin
        short_frame(8'($urandom_range(0, 4)), $urandom, $urandom_range(1, FB - 1));
      end else if (r == 7) begin
        wr(8'h04, 32'($urandom_range(0, 3)));
      end else if (m_pending) begin
        release_ready(1);
      end
    end
    if (m_pending) release_ready(1);
    tick(3);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_config_rx.md
Name: spi_config_rx

Overview:
- Upstream stage of the Mandelbrot pixel engine.
- Deserialises the breakout-board SPI stream (spi_clk, spi_en, spi_data, gated by ncs) into addressed configuration frames.
- Holds staging and active copies of the render configuration (centre, scale, iteration limit).
- Issues a valid/ready start handshake to the engine; active config changes only at a start handshake, so it is stable during a render.

Parameters:
- DATA_W, 32, width of the data field of each frame and of the centre/scale registers.
- SYNC_STAGES, 2, flop stages on each asynchronous SPI input (legal values ≥ 2).
- MAX_ITER_RST, 16'd255, reset value of the iteration-limit registers.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ncs  in  1  chip select, active low; high means all SPI activity is ignored.
- spi_clk  in  1  SPI clock, asynchronous; data is sampled on its rising edge.
- spi_en  in  1  frame enable, asynchronous; high for the duration of a frame.
- spi_data  in  1  serial data, MSB first, asynchronous.
- cfg_center_x  out  DATA_W  active centre X.
- cfg_center_y  out  DATA_W  active centre Y.
- cfg_scale  out  DATA_W  active scale.
- cfg_max_iter  out  16  active iteration limit.
- start_valid  out  1  start request to the engine.
- start_ready  in  1  engine accepts the start request.
- busy  out  1  high while a frame is being shifted in or committed.
- frame_err  out  1  sticky error flag for malformed frames.

Behaviour:
- Reset:
  - cfg_* and staging registers go to 0, except cfg_max_iter and its staging register, which go to MAX_ITER_RST.
  - start_valid=0, busy=0, frame_err=0, FSM=IDLE, bit counter=0.
- Synchronisation:
  - spi_clk, spi_en and spi_data each pass through SYNC_STAGES flops.
  - An spi_clk rising edge is detected from the synchronised copy; spi_data is sampled in the same cycle as the edge.
- Frame format:
  - FRAME_BITS = 8 + DATA_W: 8-bit address, then DATA_W data bits, MSB first.
- FSM, IDLE -> SHIFT:
  - Entered when ncs=0, spi_en_s=1 and an edge is detected.
  - That first bit is shifted in and the counter is set to 1.
- FSM, SHIFT:
  - Each edge shifts in one bit and increments the counter.
  - When counter = FRAME_BITS, go to COMMIT.
- FSM, COMMIT (exactly 1 cycle):
  - Decode the address and write the staging register.
  - Then go to WAIT_EN if spi_en_s=1, else IDLE.
- FSM, WAIT_EN:
  - Further edges are ignored until spi_en_s=0, then go to IDLE. Over-length frames therefore leave no side effects.
- Short frame: spi_en_s falls in SHIFT before the counter reaches FRAME_BITS -> frame discarded, frame_err set, go to IDLE.
- ncs=1 in any state -> go to IDLE next cycle, frame discarded, frame_err unchanged.
- busy = (state != IDLE).
- Address map (any other address is silently dropped):
  - 0x00 CENTER_X
  - 0x01 CENTER_Y
  - 0x02 SCALE
  - 0x03 MAX_ITER (data[15:0])
  - 0x04 CTRL: bit0 = start, bit1 = clear frame_err
- Timing:
  - Last bit's edge detected at cycle E -> COMMIT at E+1 -> staging register updated and visible at E+2.
- Start request:
  - A CTRL write with bit0=1 sets start_valid from E+2.
  - start_valid stays high until the cycle where start_valid & start_ready (the handshake cycle H).
  - A start written while start_valid is already high is ignored; there is no queueing.
- At handshake cycle H:
  - All staging registers are copied to cfg_*, visible at H+1.
  - start_valid is low at H+1.
- Staging writes while a start is pending are allowed; the handshake copies whatever is in staging at H.
- COMMIT and handshake in the same cycle: the handshake copies the pre-write staging value; the new value stays in staging for the next start.
- CTRL with both bit1 and bit0 set: clear frame_err and raise start.
- A frame_err set and a clear in the same cycle: set wins.

Optional Feature:
- SPI_PARITY_EN defined:
  - FRAME_BITS = 9 + DATA_W; the final bit is even parity over address and data.
  - A parity mismatch in COMMIT discards the write and sets frame_err.
- SPI_PARITY_EN undefined: no parity bit and no parity check.

Decomposition:
- Package digidoggs_pkg holds:
  - address constants ADDR_CENTER_X .. ADDR_CTRL;
  - CTRL bit indices;
  - state enum (IDLE, SHIFT, COMMIT, WAIT_EN);
  - FRAME_BITS as a function of DATA_W and SPI_PARITY_EN.
- One sub-module, spi_sync_edge: synchronises all three inputs and produces spi_clk rising-edge, spi_en_s and spi_data_s.

Test Plan:
- Reset -> cfg_center_x/y=0, cfg_scale=0, cfg_max_iter=255, start_valid=0, busy=0, frame_err=0.
- Write 0x00 data 0x12345678, then CTRL=0x01, with start_ready=1 -> start_valid pulses for 1 cycle; cfg_center_x=0x12345678 one cycle after the handshake; other cfg_* unchanged.
- Write MAX_ITER=0x03E8, CTRL start with start_ready=0 for 20 cycles, then write SCALE=0x0000_0100 -> start_valid held high; cfg_* unchanged until ready rises; then cfg_max_iter=1000 and cfg_scale=0x100.
- Frame with spi_en dropped after 20 bits -> no register change, frame_err=1; then CTRL=0x02 -> frame_err=0.
- ncs raised mid-frame after 10 bits -> FSM back to IDLE, frame_err=0; the next full frame to 0x01 writes correctly.
- 45-bit frame to 0x02 (over-length) -> SCALE takes the first 32 data bits; trailing bits ignored; no error. With SPI_PARITY_EN, a bad-parity frame -> no write, frame_err=1.
